// File: rtl/lut_ram.sv
// lut_ram: distributed RAM, one synchronous write port, one
// combinational read port, valid bitmap gives zero-after-reset.
//
// Ports:
//   clk      rising-edge clock for all state updates
//   rst      synchronous active-high reset, clears valid bitmap
//   wr_en    write enable
//   wr_addr  write address (out-of-range writes are dropped)
//   wr_data  write data
//   rd_addr  read address (out-of-range reads return 0)
//   rd_data  combinational read data
module lut_ram #(
    parameter int LUT_WIDTH  = 32,
    parameter int LUT_DEPTH  = 256,
    parameter int ADDR_WIDTH =
        (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LUT_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [LUT_WIDTH-1:0]  rd_data
);

    // Depth as an ADDR_WIDTH+1 bit constant so range checks
    // compare operands of equal width.
    localparam logic [ADDR_WIDTH:0] DEPTH_W =
        LUT_DEPTH[ADDR_WIDTH:0];

    logic [LUT_WIDTH-1:0] mem [LUT_DEPTH];
    logic [LUT_DEPTH-1:0] vld = '0;

    logic                  wr_in;
    logic                  rd_in;
    logic                  wr_go;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign wr_in = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in = ({1'b0, rd_addr} < DEPTH_W);

    // Indices are forced in range so no array access ever
    // goes past the last entry; the range flags gate effect.
    assign wr_idx = wr_in ? wr_addr : '0;
    assign rd_idx = rd_in ? rd_addr : '0;

    // Reset wins over a coincident write.
    assign wr_go = !rst && wr_en && wr_in;

    // Data array has no reset so it can map to LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (wr_go) begin
            vld[wr_idx] <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_in && vld[rd_idx]) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_lut_ram.sv
// tb_lut_ram: directed and random checks of lut_ram
// with LUT_DEPTH=10000 to exercise a non-power-of-two depth.
module tb_lut_ram;

    localparam int W  = 32;
    localparam int D  = 10000;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] model [D];

    always #5 clk = ~clk;

    lut_ram #(
        .LUT_WIDTH(W),
        .LUT_DEPTH(D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    task automatic check(input string tag,
                         input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a,
                      input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag,
                          input logic [AW-1:0] a,
                          input logic [W-1:0] exp);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    function automatic logic [W-1:0] ref_rd(
        input logic [AW-1:0] a);
        if (int'(a) < D) return model[a];
        return '0;
    endfunction

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 9) == 0)
            return AW'($urandom_range(D - 4, D + 4));
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        #1;
        check("powerup_a0", rd_data, 32'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_chk("rst_a0", 14'd0, 32'h0);
        rd_chk("rst_a1", 14'd1, 32'h0);
        rd_chk("rst_alast", AW'(D - 1), 32'h0);

        // same-cycle vs next-cycle read
        wr_en   = 1'b1;
        wr_addr = 14'd5;
        wr_data = 32'hDEADBEEF;
        rd_addr = 14'd5;
        #1;
        check("rdw_before", rd_data, 32'h0);
        tick();
        check("rdw_after", rd_data, 32'hDEADBEEF);
        wr_en = 1'b0;

        // independent ports
        wr(14'd3, 32'h11111111);
        wr_en   = 1'b1;
        wr_addr = 14'd4;
        wr_data = 32'h22222222;
        rd_addr = 14'd3;
        #1;
        check("indep_pre", rd_data, 32'h11111111);
        tick();
        check("indep_post", rd_data, 32'h11111111);
        wr_en = 1'b0;
        rd_chk("indep_a4", 14'd4, 32'h22222222);

        // wr_en gating and overwrite
        wr(14'd7, 32'hA5A5A5A5);
        wr_en   = 1'b0;
        wr_addr = 14'd7;
        wr_data = 32'hFFFFFFFF;
        tick();
        rd_chk("gate_a7", 14'd7, 32'hA5A5A5A5);
        wr(14'd7, 32'h0);
        rd_chk("ovr_a7", 14'd7, 32'h0);
        wr(14'd7, 32'h1);
        wr(14'd7, 32'h2);
        rd_chk("b2b_a7", 14'd7, 32'h2);

        // reset priority and boundaries
        wr(AW'(D - 1), 32'h12345678);
        rd_chk("last_wr", AW'(D - 1), 32'h12345678);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 14'd0;
        wr_data = 32'h9;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_chk("rstpri_a0", 14'd0, 32'h0);
        rd_chk("rstpri_last", AW'(D - 1), 32'h0);
        rd_chk("rstpri_a3", 14'd3, 32'h0);
        wr(14'd0, 32'hCAFEF00D);
        rd_chk("release_a0", 14'd0, 32'hCAFEF00D);
        wr(AW'(D), 32'h55555555);
        rd_chk("oor_wr", AW'(D), 32'h0);
        rd_chk("oor_max", 14'h3FFF, 32'h0);
        rd_chk("oor_noalias", 14'd0, 32'hCAFEF00D);

        // random regression
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < D; i++) model[i] = '0;
        for (int n = 0; n < 1000; n++) begin
            logic          do_rst;
            logic          en;
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            logic [W-1:0]  wd;
            do_rst = ($urandom_range(0, 49) == 0);
            en = 1'($urandom_range(0, 1));
            wa = pick();
            wd = $urandom;
            ra = ($urandom_range(0, 1) == 1) ? wa : pick();
            rst     = do_rst;
            wr_en   = en;
            wr_addr = wa;
            wr_data = wd;
            rd_addr = ra;
            #1;
            check("rnd_pre", rd_data, ref_rd(ra));
            tick();
            if (do_rst) begin
                for (int i = 0; i < D; i++) model[i] = '0;
            end else if (en && int'(wa) < D) begin
                model[wa] = wd;
            end
            check("rnd_post", rd_data, ref_rd(ra));
        end
        rst   = 1'b0;
        wr_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
